// File: rtl/pin_ctrl_pkg.sv
// Shared definitions for the per-pin controller: register offsets inside
// the 16-word bus window, pin mode encodings, the broadcast timer-reset
// address and the square-wave generator state type.
package pin_ctrl_pkg;

  localparam logic [3:0] OFF_MODE        = 4'h0;
  localparam logic [3:0] OFF_HALF_PERIOD = 4'h1;
  localparam logic [3:0] OFF_CYCLE_COUNT = 4'h2;
  localparam logic [3:0] OFF_START       = 4'h3;
  localparam logic [3:0] OFF_STATUS      = 4'h4;
  localparam logic [3:0] OFF_EDGES       = 4'h5;

  localparam logic [2:0] MODE_HIZ  = 3'd0;
  localparam logic [2:0] MODE_LOW  = 3'd1;
  localparam logic [2:0] MODE_HIGH = 3'd2;
  localparam logic [2:0] MODE_WAVE = 3'd3;
  localparam logic [2:0] MODE_EDGE = 3'd4;

  localparam logic [15:0] BCAST_RESET_ADDR = 16'hFFFF;

  typedef enum logic [1:0] {
    WAVE_IDLE,
    WAVE_RUN,
    WAVE_DONE
  } wave_state_t;

endpackage

// File: rtl/pin_in_sync.sv
// Brings the asynchronous pin input into the clk domain and flags rising
// edges.
// Ports:
//   clk, rst : system clock, synchronous active-high reset
//   raw      : asynchronous pin level
//   synced   : level after two synchroniser flops
//   rise     : one-cycle pulse when synced goes 0 -> 1
module pin_in_sync (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic synced,
  output logic rise
);

  logic meta;
  logic hist;

  // Two flops for metastability, a third holds the previous synced level.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta   <= 1'b0;
      synced <= 1'b0;
      hist   <= 1'b0;
    end else begin
      meta   <= raw;
      synced <= meta;
      hist   <= synced;
    end
  end

  assign rise = synced & ~hist;

endmodule

// File: rtl/pin_controller.sv
// Per-pin bus responder. Decodes cmd_bus accesses inside a 16-word window
// at BASE_ADDR and drives the pin as hi-Z, constant low/high or a counted
// square wave, or counts rising edges on the pin input.
// Ports:
//   clk, rst           : system clock, synchronous active-high reset
//   cmd_bus_addr/data  : bus address and write data
//   cmd_bus_en/rd/wr   : cycle valid, read and write strobes
//   rd_data, rd_valid  : registered read response (rd_data is 0 when idle)
//   pin_in             : asynchronous pin input
//   pin_out, pin_oe    : pin drive value and output enable
module pin_controller
  import pin_ctrl_pkg::*;
#(
  parameter logic [18:0] BASE_ADDR = 19'h00010,
  parameter int          CNT_W     = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [18:0] cmd_bus_addr,
  input  logic [31:0] cmd_bus_data,
  input  logic        cmd_bus_en,
  input  logic        cmd_bus_rd,
  input  logic        cmd_bus_wr,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  input  logic        pin_in,
  output logic        pin_out,
  output logic        pin_oe
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [3:0]       offset;
  logic             sel, wr_hit, rd_hit, bcast, mode_wr, start_wr;
  logic [2:0]       mode_q;
  logic [CNT_W-1:0] half_period_q, cycle_count_q, edges_q, reload;
  logic             synced, rise;
  logic [31:0]      rd_next;

  wave_state_t      state_q, state_d;
  logic             wave_q, wave_d, last_q, last_d;
  logic [CNT_W-1:0] phase_q, phase_d, periods_q, periods_d;

  assign offset   = cmd_bus_addr[3:0];
  assign sel      = cmd_bus_en & (cmd_bus_addr[18:4] == BASE_ADDR[18:4]);
  assign wr_hit   = sel & cmd_bus_wr;
  assign rd_hit   = sel & cmd_bus_rd & ~cmd_bus_wr;
  assign bcast    = cmd_bus_en & cmd_bus_wr & (cmd_bus_addr[15:0] == BCAST_RESET_ADDR);
  assign mode_wr  = wr_hit & (offset == OFF_MODE);
  assign start_wr = wr_hit & (offset == OFF_START);

  // A half period of 0 behaves as 1, so the reload value bottoms out at 0.
  assign reload = (half_period_q == '0) ? '0 : half_period_q - ONE;

  pin_in_sync u_sync (
    .clk    (clk),
    .rst    (rst),
    .raw    (pin_in),
    .synced (synced),
    .rise   (rise)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q        <= MODE_HIZ;
      half_period_q <= ONE;
      cycle_count_q <= '0;
    end else if (wr_hit) begin
      case (offset)
        OFF_MODE:        mode_q        <= cmd_bus_data[2:0];
        OFF_HALF_PERIOD: half_period_q <= cmd_bus_data[CNT_W-1:0];
        OFF_CYCLE_COUNT: cycle_count_q <= cmd_bus_data[CNT_W-1:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= WAVE_IDLE;
      wave_q    <= 1'b0;
      last_q    <= 1'b0;
      phase_q   <= '0;
      periods_q <= '0;
    end else begin
      state_q   <= state_d;
      wave_q    <= wave_d;
      last_q    <= last_d;
      phase_q   <= phase_d;
      periods_q <= periods_d;
    end
  end

  // The final period is recognised at its 1->0 toggle (last_d) and the FSM
  // leaves RUN only after that low half completes. Bus events are applied
  // afterwards in rising priority: START, MODE write, broadcast.
  always_comb begin
    state_d   = state_q;
    wave_d    = wave_q;
    last_d    = last_q;
    phase_d   = phase_q;
    periods_d = periods_q;
    case (state_q)
      WAVE_RUN: begin
        if (phase_q == '0) begin
          phase_d = reload;
          if (wave_q) begin
            wave_d = 1'b0;
            last_d = (cycle_count_q != '0) && ((periods_q + ONE) == cycle_count_q);
          end else if (last_q) begin
            state_d = WAVE_DONE;
          end else begin
            wave_d    = 1'b1;
            periods_d = periods_q + ONE;
          end
        end else begin
          phase_d = phase_q - ONE;
        end
      end
      default: wave_d = 1'b0;
    endcase

    if ((start_wr && mode_q == MODE_WAVE) ||
        (mode_wr && cmd_bus_data[2:0] == MODE_WAVE)) begin
      state_d   = WAVE_RUN;
      wave_d    = 1'b1;
      last_d    = 1'b0;
      phase_d   = reload;
      periods_d = '0;
    end else if (mode_wr) begin
      state_d = WAVE_IDLE;
      wave_d  = 1'b0;
      last_d  = 1'b0;
    end

    if (bcast) begin
      state_d = WAVE_IDLE;
      wave_d  = 1'b0;
      last_d  = 1'b0;
    end
  end

  // Clears win over counting; the count sticks at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      edges_q <= '0;
    end else if (bcast || (start_wr && mode_q == MODE_EDGE) ||
                 (mode_wr && cmd_bus_data[2:0] == MODE_EDGE && mode_q != MODE_EDGE)) begin
      edges_q <= '0;
    end else if (rise && mode_q == MODE_EDGE && edges_q != '1) begin
      edges_q <= edges_q + ONE;
    end
  end

  always_comb begin
    rd_next = '0;
    case (offset)
      OFF_MODE:        rd_next = 32'(mode_q);
      OFF_HALF_PERIOD: rd_next = 32'(half_period_q);
      OFF_CYCLE_COUNT: rd_next = 32'(cycle_count_q);
      OFF_STATUS:      rd_next = {29'd0, synced, state_q == WAVE_DONE, state_q == WAVE_RUN};
      OFF_EDGES:       rd_next = 32'(edges_q);
      default:         rd_next = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_data  <= rd_hit ? rd_next : '0;
      rd_valid <= rd_hit;
    end
  end

  // Modes 5-7 fall into the hi-Z default.
  always_comb begin
    pin_oe  = 1'b0;
    pin_out = 1'b0;
    case (mode_q)
      MODE_LOW:  pin_oe = 1'b1;
      MODE_HIGH: begin
        pin_oe  = 1'b1;
        pin_out = 1'b1;
      end
      MODE_WAVE: begin
        pin_oe  = 1'b1;
        pin_out = wave_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pin_controller.sv
// Directed bench for pin_controller: mode decoding, counted and free-running
// square waves, edge counting, broadcast timer reset, read decoding and
// reset behaviour.
module tb_pin_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [18:0] cmd_bus_addr;
  logic [31:0] cmd_bus_data;
  logic        cmd_bus_en, cmd_bus_rd, cmd_bus_wr;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        pin_in;
  logic        pin_out, pin_oe;

  int checks   = 0;
  int failures = 0;

  localparam logic [18:0] BASE = 19'h00010;

  pin_controller #(.BASE_ADDR(BASE), .CNT_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_bus_addr (cmd_bus_addr),
    .cmd_bus_data (cmd_bus_data),
    .cmd_bus_en   (cmd_bus_en),
    .cmd_bus_rd   (cmd_bus_rd),
    .cmd_bus_wr   (cmd_bus_wr),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .pin_in       (pin_in),
    .pin_out      (pin_out),
    .pin_oe       (pin_oe)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after a rising edge, outputs are sampled there.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic en, input logic rd, input logic wr,
                               input logic [18:0] addr, input logic [31:0] data);
    cmd_bus_en   = en;
    cmd_bus_rd   = rd;
    cmd_bus_wr   = wr;
    cmd_bus_addr = addr;
    cmd_bus_data = data;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic busWrite(input logic [18:0] addr, input logic [31:0] data);
    applyStimulus(1'b1, 1'b0, 1'b1, addr, data);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic busRead(input logic [18:0] addr, input logic [31:0] expected,
                         input string tag);
    applyStimulus(1'b1, 1'b1, 1'b0, addr, '0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
    checkOutput({tag, "_valid"}, {31'd0, rd_valid}, 32'd1);
    checkOutput({tag, "_data"}, rd_data, expected);
    tick();
    checkOutput({tag, "_valid_end"}, {31'd0, rd_valid}, 32'd0);
  endtask

  initial begin
    logic [13:0] pattern;
    pattern = 14'b11100011100000;

    pin_in = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
    rst = 1'b1;
    tick();
    tick();
    checkOutput("rst_oe", {31'd0, pin_oe}, 32'd0);
    checkOutput("rst_out", {31'd0, pin_out}, 32'd0);
    checkOutput("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    checkOutput("rst_rd_data", rd_data, 32'd0);
    rst = 1'b0;
    tick();
    busRead(BASE + 19'h1, 32'd1, "rst_half_period");
    busRead(BASE + 19'h2, 32'd0, "rst_cycle_count");

    // Constant high, then back to hi-Z; mode 5 reads back but stays hi-Z.
    busWrite(BASE + 19'h0, 32'd2);
    checkOutput("high_oe", {31'd0, pin_oe}, 32'd1);
    checkOutput("high_out", {31'd0, pin_out}, 32'd1);
    busWrite(BASE + 19'h0, 32'd0);
    checkOutput("hiz_oe", {31'd0, pin_oe}, 32'd0);
    busWrite(BASE + 19'h0, 32'd1);
    checkOutput("low_oe", {31'd0, pin_oe}, 32'd1);
    checkOutput("low_out", {31'd0, pin_out}, 32'd0);
    busWrite(BASE + 19'h0, 32'd5);
    checkOutput("mode5_oe", {31'd0, pin_oe}, 32'd0);
    busRead(BASE + 19'h0, 32'd5, "mode5_read");

    // Two full periods of 3 high / 3 low, then held low.
    busWrite(BASE + 19'h1, 32'd3);
    busWrite(BASE + 19'h2, 32'd2);
    busWrite(BASE + 19'h0, 32'd3);
    for (int i = 0; i < 14; i++) begin
      checkOutput($sformatf("wave2_c%0d", i), {31'd0, pin_out}, {31'd0, pattern[13-i]});
      tick();
    end
    busRead(BASE + 19'h4, 32'h2, "wave2_status");

    // Half period 0 behaves as 1, infinite cycles.
    busWrite(BASE + 19'h1, 32'd0);
    busWrite(BASE + 19'h2, 32'd0);
    busWrite(BASE + 19'h0, 32'd3);
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("fast_c%0d", i), {31'd0, pin_out}, (i % 2 == 0) ? 32'd1 : 32'd0);
      tick();
    end
    busRead(BASE + 19'h4, 32'h1, "fast_status");

    // Broadcast from a foreign window stops the wave, registers kept.
    busWrite(19'h0FFFF, 32'd0);
    checkOutput("bcast_out", {31'd0, pin_out}, 32'd0);
    tick();
    checkOutput("bcast_out_hold", {31'd0, pin_out}, 32'd0);
    busRead(BASE + 19'h4, 32'h0, "bcast_status");
    busRead(BASE + 19'h0, 32'd3, "bcast_mode");

    // Edge counting on asynchronous pin_in.
    busWrite(BASE + 19'h0, 32'd4);
    checkOutput("edge_oe", {31'd0, pin_oe}, 32'd0);
    repeat (5) begin
      #3 pin_in = 1'b1;
      repeat (3) tick();
      #4 pin_in = 1'b0;
      repeat (3) tick();
    end
    repeat (4) tick();
    checkOutput("edge_pre_valid", {31'd0, rd_valid}, 32'd0);
    busRead(BASE + 19'h5, 32'd5, "edges5");
    busWrite(BASE + 19'h3, 32'd0);
    busRead(BASE + 19'h5, 32'd0, "edges_cleared");
    pin_in = 1'b1;
    repeat (4) tick();
    busRead(BASE + 19'h4, 32'h4, "status_pin_high");
    busRead(BASE + 19'h5, 32'd1, "edges1");
    busRead(BASE + 19'h3, 32'd0, "start_read");

    // Read decoding: unused offset, foreign window, rd+wr together.
    busRead(BASE + 19'h9, 32'd0, "unused_off");
    applyStimulus(1'b1, 1'b1, 1'b0, 19'h00020, '0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
    checkOutput("foreign_valid", {31'd0, rd_valid}, 32'd0);
    checkOutput("foreign_data", rd_data, 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, BASE + 19'h1, 32'd7);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
    checkOutput("rdwr_valid", {31'd0, rd_valid}, 32'd0);
    busRead(BASE + 19'h1, 32'd7, "rdwr_written");

    // Reset in the middle of a running wave, together with a read strobe.
    busWrite(BASE + 19'h1, 32'd2);
    busWrite(BASE + 19'h0, 32'd3);
    tick();
    checkOutput("pre_rst_oe", {31'd0, pin_oe}, 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b0, BASE + 19'h0, '0);
    rst = 1'b1;
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
    checkOutput("mid_rst_oe", {31'd0, pin_oe}, 32'd0);
    checkOutput("mid_rst_out", {31'd0, pin_out}, 32'd0);
    checkOutput("mid_rst_valid", {31'd0, rd_valid}, 32'd0);
    checkOutput("mid_rst_data", rd_data, 32'd0);
    rst = 1'b0;
    tick();
    busRead(BASE + 19'h0, 32'd0, "post_rst_mode");
    busRead(BASE + 19'h1, 32'd1, "post_rst_half");
    busRead(BASE + 19'h5, 32'd0, "post_rst_edges");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
